// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter with inhibit, ACK check and timeout
//
// Sends one byte to a PS/2 device: holds the clock low (inhibit), drives the start bit,
// then shifts 8 data bits LSB first, odd parity and stop on falling device-clock edges,
// and checks the device ACK on the following falling edge.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   ps2_clk      PS/2 clock pad input
//   ps2_data     PS/2 data pad input
//   samplen      sampling strobe for ps2_clk/ps2_data
//   wren, d      start a frame with byte d (accepted only when idle)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   busy         frame in progress
//   done         one-cycle end-of-frame pulse
//   error        last frame failed (no ACK or timeout), valid from done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2400,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       samplen,
    input  logic       wren,
    input  logic [7:0] d,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int CW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAIT
    } state_t;

    // Line sampling, same edge detector as the receiver uses.
    logic [1:0] clk_hist;
    logic [1:0] data_hist;
    logic       fall_ce;
    logic       bus_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_hist  <= 2'b11;
            data_hist <= 2'b11;
            fall_ce   <= 1'b0;
        end else begin
            fall_ce <= 1'b0;
            if (samplen) begin
                clk_hist  <= {clk_hist[0], ps2_clk};
                data_hist <= {data_hist[0], ps2_data};
                fall_ce   <= clk_hist[0] & ~ps2_clk;
            end
        end
    end

    assign bus_idle = (clk_hist == 2'b11) && (data_hist == 2'b11);

    state_t          state, state_n;
    logic [9:0]      shift, shift_n;
    logic [3:0]      bitcnt, bitcnt_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [TW-1:0]   tmo, tmo_n;
    logic            clk_oe_n, data_oe_n, busy_n, done_n, error_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            shift       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            tmo         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            bitcnt      <= bitcnt_n;
            cnt         <= cnt_n;
            tmo         <= tmo_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bitcnt_n  = bitcnt;
        cnt_n     = cnt;
        tmo_n     = tmo;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        busy_n    = busy;
        done_n    = 1'b0;
        error_n   = error;

        case (state)
            S_IDLE: begin
                // The cycle showing done is still the tail of the old frame.
                if (wren && !done) begin
                    shift_n  = {1'b1, ~^d, d};
                    busy_n   = 1'b1;
                    error_n  = 1'b0;
                    clk_oe_n = 1'b1;
                    cnt_n    = CNT_LOAD;
                    state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == '0) begin
                    data_oe_n = 1'b1;
                    clk_oe_n  = 1'b0;
                    bitcnt_n  = 4'd10;
                    tmo_n     = TMO_LOAD;
                    state_n   = S_SEND;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            S_SEND, S_ACK, S_WAIT: begin
                if (tmo == '0) begin
                    // Expiry wins over a coincident falling edge.
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    error_n   = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = S_IDLE;
                end else begin
                    tmo_n = tmo - TMO_ONE;
                    if (state == S_SEND) begin
                        if (fall_ce) begin
                            data_oe_n = ~shift[0];
                            shift_n   = {1'b0, shift[9:1]};
                            bitcnt_n  = bitcnt - 4'd1;
                            if (bitcnt == 4'd1) begin
                                state_n = S_ACK;
                            end
                        end
                    end else if (state == S_ACK) begin
                        if (fall_ce) begin
                            if (data_hist[0]) begin
                                error_n = 1'b1;
                            end
                            state_n = S_WAIT;
                        end
                    end else begin
                        if (bus_idle) begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       samplen = 1'b1;
    logic       wren = 1'b0;
    logic [7:0] d = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, error;
    wire        ps2_clk;
    wire        ps2_data;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .samplen    (samplen),
        .wren       (wren),
        .d          (d),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int win_s = -1000;
    int done_cnt = 0;
    logic [10:0] fbits;
    logic [10:0] mexp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2) == 0;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Per-cycle protocol checks against the bench's own view of the frame.
    logic rst_edge;
    logic prev_data_oe = 1'b0, prev_clk_oe = 1'b0, prev_done = 1'b0;
    logic exp_clk_oe;
    logic allowed;
    always begin
        @(posedge clk);
        rst_edge = reset;
        #2;
        if (cyc >= 2) begin
            exp_clk_oe = (cyc >= win_s) && (cyc < win_s + INH);
            chk("clk_oe_window", ps2_clk_oe, exp_clk_oe);
            if (!busy) chk("idle_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            if (done) begin
                chk("done_busy_low", busy, 0);
                chk("done_single_cycle", prev_done, 0);
            end
            if (ps2_data_oe != prev_data_oe) begin
                allowed = !dev_clk || (prev_clk_oe && !ps2_clk_oe) || done || rst_edge;
                chk("data_oe_change_when_clock_low", allowed, 1);
            end
            if (done && !prev_done) done_cnt++;
        end
        prev_data_oe = ps2_data_oe;
        prev_clk_oe  = ps2_clk_oe;
        prev_done    = done;
    end

    task automatic start_frame(input logic [7:0] b);
        @(posedge clk);
        #1;
        d     = b;
        wren  = 1'b1;
        win_s = cyc + 1;
        @(posedge clk);
        #1;
        wren = 1'b0;
    endtask

    // Device: waits for the request, then clocks npulse pulses (16 clk period),
    // reading the line just before each rising edge; optionally ACKs on pulse 11.
    task automatic dev_run(input int npulse, input bit ack, output logic [10:0] bits);
        bit ok;
        bits = '0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) ok = 1;
        end
        chk("dev_inhibit_seen", ok, 1);
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe) ok = 1;
        end
        chk("dev_release_seen", ok, 1);
        if (!ok) return;
        bits[0] = ps2_data;
        repeat (4) @(negedge clk);
        for (int p = 1; p <= npulse; p++) begin
            dev_clk = 1'b0;
            repeat (8) @(negedge clk);
            if (p <= 10) bits[p] = ps2_data;
            dev_clk = 1'b1;
            if (p == 10 && ack) dev_data = 1'b0;
            if (p == 11) dev_data = 1'b1;
            if (p < npulse) repeat (8) @(negedge clk);
        end
    endtask

    task automatic wait_done(input logic exp_err, input int max_cyc, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(posedge clk);
            #3;
            if (done) got = 1;
        end
        chk({name, "_done_seen"}, got, 1);
        if (got) begin
            chk({name, "_error"}, error, exp_err);
            chk({name, "_busy"}, busy, 0);
            chk({name, "_lines"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
        end
    endtask

    initial begin
        int  t_done;
        bit  got;
        int  base_cnt;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        reset = 1'b0;

        // 1: basic ED frame with ACK
        start_frame(8'hED);
        chk("t1_busy_after_wren", busy, 1);
        dev_run(11, 1, fbits);
        wait_done(1'b0, 60, "t1");
        chk("t1_frame_literal", fbits, 11'h7DA);
        chk("t1_frame_model", fbits, model_frame(8'hED));

        // 2: parity extremes, second wren the cycle right after done
        start_frame(8'h00);
        dev_run(11, 1, fbits);
        wait_done(1'b0, 60, "t2a");
        chk("t2a_frame_literal", fbits, 11'h600);
        start_frame(8'h01);
        dev_run(11, 1, fbits);
        wait_done(1'b0, 60, "t2b");
        chk("t2b_frame_literal", fbits, 11'h402);
        chk("t2b_frame_model", fbits, model_frame(8'h01));

        // 3: device omits ACK
        start_frame(8'h96);
        dev_run(11, 0, fbits);
        wait_done(1'b1, 60, "t3");
        chk("t3_frame_model", fbits, model_frame(8'h96));

        // 4: device never clocks
        start_frame(8'h5A);
        got = 0;
        t_done = 0;
        for (int i = 0; i < INH + TMO + 100 && !got; i++) begin
            @(posedge clk);
            #3;
            if (done) begin
                got = 1;
                t_done = cyc;
            end
        end
        chk("t4_done_seen", got, 1);
        chk("t4_timeout_cycle", t_done, win_s + INH + TMO);
        chk("t4_error", error, 1);
        chk("t4_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // 5: wren during a frame is ignored
        base_cnt = done_cnt;
        start_frame(8'hED);
        fork
            dev_run(11, 1, fbits);
            begin
                repeat (60) @(posedge clk);
                #1;
                d    = 8'hFF;
                wren = 1'b1;
                @(posedge clk);
                #1;
                wren = 1'b0;
            end
        join
        wait_done(1'b0, 60, "t5");
        chk("t5_frame_model", fbits, model_frame(8'hED));
        repeat (100) @(posedge clk);
        chk("t5_single_done", done_cnt - base_cnt, 1);

        // 6: reset after the 4th data bit, then a clean frame
        start_frame(8'hA5);
        dev_run(4, 1, fbits);
        mexp = model_frame(8'hA5);
        chk("t6_partial_bits", fbits[4:0], mexp[4:0]);
        chk("t6_data_oe_before_reset", ps2_data_oe, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_reset_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("t6_reset_busy", busy, 0);
        reset = 1'b0;
        start_frame(8'h3C);
        dev_run(11, 1, fbits);
        wait_done(1'b0, 60, "t6");
        chk("t6_frame_model", fbits, model_frame(8'h3C));

        repeat (20) @(posedge clk);
        chk("total_done_pulses", done_cnt, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
